wb_cmd_master: RTL
==================

Name: wb_cmd_master

Overview:
Wishbone initiator that drives the FPGA register bus (ADR/CYC/STB/WE/BYTE_STB/DAT, ACK-terminated) from a queued command stream. Commands (read/write, word address, byte strobes, data) enter a small FIFO and are issued as single classic Wishbone cycles, one at a time. Each command produces exactly one response. The block sits between a local controller (test sequencer or soft-state machine) and the existing register-file slaves.

Parameters:
ADDRWIDTH, 7, word address width; matches the slave register decode.
DATAWIDTH, 32, data bus width.
CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2.
TIMEOUT_CYCLES, 255, bus cycles without ACK before abort; used only with WB_TIMEOUT_EN.

Ports:
WBs_CLK_i  in  1  single clock; all logic on posedge.
WBs_RST_i  in  1  reset, synchronous, active-low.
cmd_valid_i  in  1  command offered.
cmd_ready_o  out  1  FIFO not full.
cmd_we_i  in  1  1=write, 0=read.
cmd_adr_i  in  ADDRWIDTH  word address.
cmd_byte_stb_i  in  4  byte enables.
cmd_dat_i  in  DATAWIDTH  write data.
rsp_valid_o  out  1  response available.
rsp_ready_i  in  1  response consumed.
rsp_we_o  out  1  echo of command type.
rsp_err_o  out  1  cycle aborted by timeout.
rsp_dat_o  out  DATAWIDTH  read data; 0 for writes and errors.
WBm_ADR_o  out  ADDRWIDTH  bus address.
WBm_CYC_o  out  1  cycle.
WBm_STB_o  out  1  strobe; always equal to WBm_CYC_o.
WBm_WE_o  out  1  write enable.
WBm_BYTE_STB_o  out  4  byte select.
WBm_DAT_o  out  DATAWIDTH  write data.
WBm_DAT_i  in  DATAWIDTH  read data.
WBm_ACK_i  in  1  acknowledge.
busy_o  out  1  FSM not IDLE, or FIFO non-empty.

Behaviour:
- Reset (WBs_RST_i=0 at posedge), values at the next edge:
  - FIFO flushed.
  - FSM to IDLE.
  - Every output 0, except cmd_ready_o=1.
  - Reset during an active cycle drops CYC/STB at that same edge. The command is lost and no response is issued.
- FIFO:
  - Push when cmd_valid_i & cmd_ready_o.
  - cmd_ready_o = !full, registered from occupancy. A pop in the same cycle does not un-block a push while full.
  - Order is preserved.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If FIFO non-empty and rsp_valid_o=0: pop head and register it onto the WBm_* outputs; CYC=STB=1 from the next edge; go to BUS.
  - Latency: a command pushed into an empty FIFO at edge N appears on the bus after edge N+1.
- BUS:
  - ADR/WE/BYTE_STB/DAT are held stable.
  - On a posedge with WBm_ACK_i=1:
    - Capture WBm_DAT_i into rsp_dat_o (reads) or 0 (writes).
    - rsp_we_o=cmd type, rsp_err_o=0.
    - CYC=STB=0, rsp_valid_o=1, go to RESP.
  - A registered-ACK slave therefore yields CYC high for exactly 2 cycles.
- RESP:
  - rsp_valid_o and rsp_* are held until rsp_ready_i=1 at a posedge; then rsp_valid_o=0 and go to IDLE.
  - CYC stays low for at least 1 cycle between consecutive bus cycles. This prevents a slave from seeing a stale ACK as a new request.
- Other rules:
  - WBm_ACK_i outside BUS is ignored.
  - WBm_DAT_o keeps the last command's data when CYC=0.
  - At most one bus cycle is outstanding; no pipelining or bursts.

Optional Feature:
WB_TIMEOUT_EN defined:
- A counter clears on entry to BUS and increments each BUS cycle without ACK.
- When it reaches TIMEOUT_CYCLES (CYC has been high TIMEOUT_CYCLES cycles): drop CYC/STB, rsp_err_o=1, rsp_dat_o=0, go to RESP.
- ACK and timeout at the same edge: ACK wins and err=0.

WB_TIMEOUT_EN undefined:
- No counter; BUS waits for ACK indefinitely.
- rsp_err_o is tied 0.

Test Plan:
1. Write adr 0x02, dat 0x0000_1234, stb 0011; slave model with registered ACK -> CYC/STB high exactly 2 cycles with WE=1, BYTE_STB=0011; rsp_we=1, rsp_err=0, rsp_dat=0; slave scratch register then reads 0x1234.
2. Read adr 0x00 -> rsp_valid with rsp_dat=0x0000A5BD, rsp_we=0; read adr 0x7F -> rsp_dat=0xFABDEFAC.
3. Hold rsp_ready_i=0 and push 6 commands -> first completes and waits in RESP; 4 more accepted; cmd_ready_o=0 on the 6th; no second bus cycle until rsp_ready_i=1.
4. rsp_ready_i=1; write 0x08, 0x09, 0x0A, 0x0B with data 0x123, 0x456, 0x789, 0xABC -> four bus cycles in order, each separated by ≥1 idle cycle, four responses with err=0.
5. WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ACKs -> CYC high 16 cycles then low; rsp_err=1, rsp_dat=0; the next command proceeds normally.
6. Drive WBs_RST_i=0 for one edge while CYC=1 with 2 commands queued -> CYC=0, rsp_valid=0, cmd_ready=1, busy_o=0 after that edge; no response is issued for the aborted or queued commands.

Source files
------------

// File: rtl/wb_cmd_master.sv
// Queued-command Wishbone initiator: a small FIFO feeds single classic cycles, one response per command.
// Optional bus-cycle timeout is compiled in with `define WB_TIMEOUT_EN.
module wb_cmd_master #(
    parameter int ADDRWIDTH      = 7,
    parameter int DATAWIDTH      = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic [3:0]           cmd_byte_stb_i,
    input  logic [DATAWIDTH-1:0] cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_we_o,
    output logic                 rsp_err_o,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i,
    output logic                 busy_o
);
    localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CW = $clog2(CMD_DEPTH + 1);
    localparam int EW = 1 + ADDRWIDTH + 4 + DATAWIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state;

    logic [EW-1:0] fifo_mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          push, pop;

    // Pushes are gated by the registered ready, so a full FIFO stays blocked even during a pop.
    assign push      = cmd_valid_i & cmd_ready_o;
    assign pop       = (state == IDLE) && (count != '0) && !rsp_valid_o;
    assign WBm_STB_o = WBm_CYC_o;
    assign busy_o    = (state != IDLE) || (count != '0);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (push)
            fifo_mem[wr_ptr] <= {cmd_we_i, cmd_adr_i, cmd_byte_stb_i, cmd_dat_i};
    end

`ifdef WB_TIMEOUT_EN
    logic [TW-1:0] to_cnt;
`else
    // Timeout parameter has no effect in this build; fold it away explicitly.
    logic unused_timeout;
    assign unused_timeout = ^TW'(TIMEOUT_CYCLES);
    assign rsp_err_o      = 1'b0;
`endif

    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_i) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            cmd_ready_o    <= 1'b1;
            WBm_CYC_o      <= 1'b0;
            WBm_WE_o       <= 1'b0;
            WBm_ADR_o      <= '0;
            WBm_BYTE_STB_o <= '0;
            WBm_DAT_o      <= '0;
            rsp_valid_o    <= 1'b0;
            rsp_we_o       <= 1'b0;
            rsp_dat_o      <= '0;
`ifdef WB_TIMEOUT_EN
            rsp_err_o      <= 1'b0;
            to_cnt         <= '0;
`endif
        end else begin
            count       <= count_next;
            cmd_ready_o <= (count_next != CW'(CMD_DEPTH));
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            case (state)
                IDLE: begin
                    if (pop) begin
                        {WBm_WE_o, WBm_ADR_o, WBm_BYTE_STB_o, WBm_DAT_o} <= fifo_mem[rd_ptr];
                        WBm_CYC_o <= 1'b1;
                        state     <= BUS;
`ifdef WB_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end
                BUS: begin
                    // ACK takes priority over an expiring timeout on the same edge.
                    if (WBm_ACK_i) begin
                        WBm_CYC_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_we_o    <= WBm_WE_o;
                        rsp_dat_o   <= WBm_WE_o ? '0 : WBm_DAT_i;
`ifdef WB_TIMEOUT_EN
                        rsp_err_o   <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        WBm_CYC_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_we_o    <= WBm_WE_o;
                        rsp_dat_o   <= '0;
                        rsp_err_o   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
